// File: rtl/fifo_wr_ingress_if.sv
// rtl/fifo_wr_ingress_if.sv - producer, write-handler and memory-port signals of the write ingress
interface fifo_wr_ingress_if #(
    parameter int D  = 8,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [D-1:0]  wrPtr;
    logic [D-1:0]  rdPtr;
    logic          fifo_full;
    logic          wren;
    logic [D-2:0]  mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [D-1:0]  wr_level;
    logic          almost_full;
`ifdef WR_INGRESS_STATS_EN
    logic [31:0]   acc_cnt;
    logic [31:0]   stall_cnt;
`endif

    // ingress block side
    modport slave (
        input  in_valid, in_data, wrPtr, rdPtr, fifo_full,
        output in_ready, wren, mem_waddr, mem_wdata, wr_level, almost_full
`ifdef WR_INGRESS_STATS_EN
        , output acc_cnt, stall_cnt
`endif
    );

    // producer / write handler / memory side
    modport master (
        output in_valid, in_data, wrPtr, rdPtr, fifo_full,
        input  in_ready, wren, mem_waddr, mem_wdata, wr_level, almost_full
`ifdef WR_INGRESS_STATS_EN
        , input acc_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/fifo_wr_ingress.sv
// rtl/fifo_wr_ingress.sv - write-domain ingress: 2-entry skid buffer, wren issue, fill level (optional counters: WR_INGRESS_STATS_EN)
module fifo_wr_ingress #(
    parameter int D         = 8,
    parameter int DEPTH     = 90,
    parameter int DW        = 8,
    parameter int AF_THRESH = 80
) (
    input logic               wrclk,
    input logic               wrrst,
    fifo_wr_ingress_if.slave  bus
);
    localparam logic [D-1:0] DEPTH_W = D'(DEPTH);
    localparam logic [D-1:0] AF_W    = D'(AF_THRESH);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          in_ready_q, in_ready_d;
    logic [D-1:0]  wr_level_q, wr_level_d;
    logic          almost_full_q, almost_full_d;
    logic          accept;
    logic          pop;
    logic [D-1:0]  w_idx, r_idx;

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = (cnt_q != 2'd0) && !bus.fifo_full;

    // skid buffer: tail takes new words, head feeds the memory, count tracks occupancy
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({accept, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = bus.in_data;
                else               tail_d = bus.in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = bus.in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.in_data;
                end
            end
            default: ;
        endcase
        in_ready_d = (cnt_d < 2'd2);
    end

    // occupancy from the wrap-bit pointer pair; modulo-2^D arithmetic is exact since the result never exceeds DEPTH
    always_comb begin
        w_idx = {1'b0, bus.wrPtr[D-2:0]};
        r_idx = {1'b0, bus.rdPtr[D-2:0]};
        if (bus.wrPtr[D-1] == bus.rdPtr[D-1]) wr_level_d = w_idx - r_idx;
        else                                  wr_level_d = DEPTH_W - r_idx + w_idx;
        almost_full_d = (wr_level_d >= AF_W);
    end

    // state registers; reset discards buffered words immediately
    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst) begin
            cnt_q         <= 2'd0;
            head_q        <= '0;
            tail_q        <= '0;
            in_ready_q    <= 1'b0;
            wr_level_q    <= '0;
            almost_full_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            in_ready_q    <= in_ready_d;
            wr_level_q    <= wr_level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.wren        = pop;
    assign bus.mem_waddr   = bus.wrPtr[D-2:0];
    assign bus.mem_wdata   = head_q;
    assign bus.wr_level    = wr_level_q;
    assign bus.almost_full = almost_full_q;

`ifdef WR_INGRESS_STATS_EN
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // saturating counters of accepted words and of cycles blocked by a full FIFO
    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (acc_cnt_q != 32'hFFFF_FFFF))
            acc_cnt_d = acc_cnt_q + 32'd1;
        if ((cnt_q != 2'd0) && bus.fifo_full && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // counter registers
    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst) begin
            acc_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.acc_cnt   = acc_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
